// File: rtl/lcd_port_driver_if.sv
// Command/LCD-pin bundle between the LCD PIO side and the LCD port driver.
interface lcd_port_driver_if;
    logic [31:0] cmd_word;
    logic [7:0]  lcd_data;
    logic        lcd_rs;
    logic        lcd_rw;
    logic        lcd_en;
    logic        busy;
    logic        done;

    modport master (
        output cmd_word,
        input  lcd_data, lcd_rs, lcd_rw, lcd_en, busy, done
    );

    modport slave (
        input  cmd_word,
        output lcd_data, lcd_rs, lcd_rw, lcd_en, busy, done
    );
endinterface

// File: rtl/lcd_port_driver.sv
// Toggle-request PIO word to one timed HD44780 write cycle.
// Optional LCD_LONG_EXEC_EN: long execution wait for clear/home commands.
module lcd_port_driver #(
    parameter int CNT_W   = 20,
    parameter int T_SETUP = 4,
    parameter int T_PULSE = 25,
    parameter int T_HOLD  = 4,
    parameter int T_EXEC  = 2000,
    parameter int T_CLEAR = 80000
) (
    input logic             clk,
    input logic             reset_n,
    lcd_port_driver_if.slave lcd
);
    typedef enum logic [2:0] {
        IDLE, SETUP, PULSE, HOLD, EXEC
    } state_t;

    localparam logic [CNT_W-1:0] SET_L = CNT_W'(T_SETUP - 1);
    localparam logic [CNT_W-1:0] PUL_L = CNT_W'(T_PULSE - 1);
    localparam logic [CNT_W-1:0] HLD_L = CNT_W'(T_HOLD - 1);
    localparam logic [CNT_W-1:0] EXE_L = CNT_W'(T_EXEC - 1);
    localparam logic [CNT_W-1:0] CLR_L = CNT_W'(T_CLEAR - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] exec_len, len_nxt;
    logic             last_tog, tog_nxt;
    logic [7:0]       data_q, data_nxt;
    logic             rs_q, rs_nxt;
    logic             en_q, en_nxt;
    logic             busy_q, busy_nxt;
    logic             done_q, done_nxt;
    logic             req;
    logic [CNT_W-1:0] sel_len;

    assign req = lcd.cmd_word[31] != last_tog;

`ifdef LCD_LONG_EXEC_EN
    logic is_clr;
    assign is_clr = !lcd.cmd_word[8] &&
                    (lcd.cmd_word[7:0] == 8'h01 ||
                     lcd.cmd_word[7:0] == 8'h02 ||
                     lcd.cmd_word[7:0] == 8'h03);
    assign sel_len = is_clr ? CLR_L : EXE_L;
`else
    assign sel_len = EXE_L;
`endif

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 1'b1;
        len_nxt   = exec_len;
        tog_nxt   = last_tog;
        data_nxt  = data_q;
        rs_nxt    = rs_q;
        unique case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (req) begin
                    data_nxt  = lcd.cmd_word[7:0];
                    rs_nxt    = lcd.cmd_word[8];
                    tog_nxt   = lcd.cmd_word[31];
                    len_nxt   = sel_len;
                    state_nxt = SETUP;
                end
            end
            SETUP: if (cnt == SET_L) begin
                state_nxt = PULSE;
                cnt_nxt   = '0;
            end
            PULSE: if (cnt == PUL_L) begin
                state_nxt = HOLD;
                cnt_nxt   = '0;
            end
            HOLD: if (cnt == HLD_L) begin
                state_nxt = EXEC;
                cnt_nxt   = '0;
            end
            EXEC: if (cnt == exec_len) begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
        // Outputs are registered from the next state so they align with it.
        busy_nxt = state_nxt != IDLE;
        en_nxt   = state_nxt == PULSE;
        done_nxt = state_nxt == EXEC && cnt_nxt == len_nxt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            cnt      <= '0;
            exec_len <= EXE_L;
            last_tog <= 1'b0;
            data_q   <= 8'h00;
            rs_q     <= 1'b0;
            en_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            exec_len <= len_nxt;
            last_tog <= tog_nxt;
            data_q   <= data_nxt;
            rs_q     <= rs_nxt;
            en_q     <= en_nxt;
            busy_q   <= busy_nxt;
            done_q   <= done_nxt;
        end
    end

    assign lcd.lcd_data = data_q;
    assign lcd.lcd_rs   = rs_q;
    assign lcd.lcd_rw   = 1'b0;
    assign lcd.lcd_en   = en_q;
    assign lcd.busy     = busy_q;
    assign lcd.done     = done_q;

    logic unused_ok;
    assign unused_ok = ^{lcd.cmd_word[30:9], CLR_L};
endmodule

// File: tb/tb_lcd_port_driver.sv
// Directed bench for lcd_port_driver with a busy-cycle-index reference model.
module tb_lcd_port_driver;
    localparam int TS = 2;
    localparam int TP = 3;
    localparam int TH = 2;
    localparam int TE = 5;
    localparam int TC = 20;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    lcd_port_driver_if m ();

    lcd_port_driver #(
        .CNT_W(20), .T_SETUP(TS), .T_PULSE(TP),
        .T_HOLD(TH), .T_EXEC(TE), .T_CLEAR(TC)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .lcd(m.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)",
                     name, act, act, exp, exp);
        end
    endtask

    function automatic int len_of(input logic [31:0] w);
`ifdef LCD_LONG_EXEC_EN
        if (!w[8] && (w[7:0] == 8'h01 || w[7:0] == 8'h02 ||
                      w[7:0] == 8'h03))
            return TS + TP + TH + TC;
`endif
        return TS + TP + TH + TE;
    endfunction

    // Model: pos is the 1-based busy cycle index of the running write.
    int         pos;
    int         mlen;
    logic       mtog;
    logic [7:0] mdata;
    logic       mrs;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pos   <= 0;
            mlen  <= 0;
            mtog  <= 1'b0;
            mdata <= 8'h00;
            mrs   <= 1'b0;
        end else if (pos == 0) begin
            if (m.cmd_word[31] != mtog) begin
                mtog  <= m.cmd_word[31];
                mdata <= m.cmd_word[7:0];
                mrs   <= m.cmd_word[8];
                mlen  <= len_of(m.cmd_word);
                pos   <= 1;
            end
        end else if (pos == mlen) begin
            pos <= 0;
        end else begin
            pos <= pos + 1;
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            chk("busy", int'(m.busy), int'(pos != 0));
            chk("en", int'(m.lcd_en), int'(pos > TS && pos <= TS + TP));
            chk("done", int'(m.done), int'(pos != 0 && pos == mlen));
            chk("data", int'(m.lcd_data), int'(mdata));
            chk("rs", int'(m.lcd_rs), int'(mrs));
            chk("rw", int'(m.lcd_rw), 0);
        end
    end

    int   en_rises = 0;
    int   done_cnt = 0;
    logic en_d = 1'b0;

    always @(negedge clk) begin
        en_d <= m.lcd_en;
        if (m.lcd_en && !en_d) en_rises <= en_rises + 1;
        if (m.done) done_cnt <= done_cnt + 1;
    end

    task automatic measure(input bit mid, input logic [31:0] mv,
                           output int wait_c, output int len,
                           output int en_first, output int en_n,
                           output int done_at, output int d,
                           output int r);
        wait_c = 0; len = 0; en_first = 0;
        en_n = 0; done_at = 0; d = 0; r = 0;
        @(negedge clk);
        while (!m.busy && wait_c < 40) begin
            wait_c++;
            @(negedge clk);
        end
        if (!m.busy) begin
            wait_c = -1;
            return;
        end
        d = int'(m.lcd_data);
        r = int'(m.lcd_rs);
        while (m.busy && len < 100) begin
            len++;
            if (m.lcd_en) begin
                en_n++;
                if (en_first == 0) en_first = len;
            end
            if (m.done) done_at = len;
            if (mid && len == 4) m.cmd_word = mv;
            @(negedge clk);
        end
    endtask

    int w, l, ef, en, da, d, r, k, e0;

    initial begin
        m.cmd_word = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(m.busy), 0);
        chk("rst_en", int'(m.lcd_en), 0);
        chk("rst_data", int'(m.lcd_data), 0);
        chk("rst_done", int'(m.done), 0);
        reset_n = 1'b1;

        repeat (50) @(negedge clk);
        chk("t1_en_rises", en_rises, 0);
        chk("t1_done_cnt", done_cnt, 0);

        m.cmd_word = 32'h8000_0141;
        measure(1'b1, 32'h0000_0038, w, l, ef, en, da, d, r);
        chk("t2_wait", w, 0);
        chk("t2_len", l, 12);
        chk("t2_en_first", ef, 3);
        chk("t2_en_cycles", en, 3);
        chk("t2_done_at", da, 12);
        chk("t2_data", d, 'h41);
        chk("t2_rs", r, 1);

        measure(1'b0, 32'h0, w, l, ef, en, da, d, r);
        chk("t3_gap", w, 0);
        chk("t3_len", l, 12);
        chk("t3_data", d, 'h38);
        chk("t3_rs", r, 0);

        e0 = en_rises;
        m.cmd_word = 32'h0000_00AA;
        repeat (30) @(negedge clk);
        chk("t4_no_pulse", en_rises - e0, 0);
        chk("t4_data", int'(m.lcd_data), 'h38);

        m.cmd_word = 32'h8000_0001;
        measure(1'b0, 32'h0, w, l, ef, en, da, d, r);
`ifdef LCD_LONG_EXEC_EN
        chk("t5_clr_len", l, 27);
`else
        chk("t5_clr_len", l, 12);
`endif
        m.cmd_word = 32'h0000_0004;
        measure(1'b0, 32'h0, w, l, ef, en, da, d, r);
        chk("t5_04_len", l, 12);
        chk("t5_04_data", d, 'h04);

        m.cmd_word = 32'h8000_0055;
        k = 0;
        while (!m.lcd_en && k < 30) begin
            k++;
            @(negedge clk);
        end
        chk("t6_reach_pulse", int'(m.lcd_en), 1);
        #1 reset_n = 1'b0;
        #1;
        chk("t6_rst_en", int'(m.lcd_en), 0);
        chk("t6_rst_busy", int'(m.busy), 0);
        chk("t6_rst_data", int'(m.lcd_data), 0);
        repeat (2) @(negedge clk);
        e0 = en_rises;
        reset_n = 1'b1;
        measure(1'b0, 32'h0, w, l, ef, en, da, d, r);
        chk("t6_restart_len", l, 12);
        chk("t6_restart_data", d, 'h55);
        repeat (30) @(negedge clk);
        chk("t6_one_txn", en_rises - e0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
